// File: rtl/mips_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, IF/ID pipeline register, stall and redirect handling.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module mips_fetch_stage #(
   parameter int                  PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stall_if,
   input  logic                branch_taken,
   input  logic [15:0]         branch_offset,
   input  logic                jump,
   input  logic [25:0]         jump_index,
   input  logic [31:0]         imem_rdata,
   output logic [PC_WIDTH-1:0] imem_addr,
   output logic [PC_WIDTH-1:0] pc,
   output logic [31:0]         instr,
   output logic [31:0]         ifid_instr,
   output logic [PC_WIDTH-1:0] ifid_pc_plus4,
   output logic                ifid_valid,
   output logic [31:0]         cnt_cycles,
   output logic [31:0]         cnt_stalls,
   output logic [31:0]         cnt_flushes
);

   logic [PC_WIDTH-1:0] pc_plus4;
   logic [PC_WIDTH-1:0] branch_target;
   logic [PC_WIDTH-1:0] jump_target;

   assign imem_addr     = pc;
   assign instr         = imem_rdata;
   assign pc_plus4      = pc + PC_WIDTH'(4);
   assign branch_target = ifid_pc_plus4 + {{(PC_WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
   assign jump_target   = {ifid_pc_plus4[PC_WIDTH-1 -: 4], jump_index, 2'b00};

   // Stall outranks redirects: the ID instruction repeats and reasserts them next cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc            <= RESET_PC;
         ifid_instr    <= '0;
         ifid_pc_plus4 <= '0;
         ifid_valid    <= 1'b0;
      end else if (!stall_if) begin
         if (branch_taken) begin
            pc            <= branch_target;
            ifid_instr    <= '0;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
         end else if (jump) begin
            pc            <= jump_target;
            ifid_instr    <= '0;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
         end else begin
            pc            <= pc_plus4;
            ifid_instr    <= imem_rdata;
            ifid_pc_plus4 <= pc_plus4;
            ifid_valid    <= 1'b1;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic redirect;

   assign redirect = !stall_if && (branch_taken || jump);

   // Saturating counters so long runs never wrap back to small values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_cycles  <= '0;
         cnt_stalls  <= '0;
         cnt_flushes <= '0;
      end else begin
         if (cnt_cycles != 32'hFFFF_FFFF) begin
            cnt_cycles <= cnt_cycles + 32'd1;
         end
         if (stall_if && (cnt_stalls != 32'hFFFF_FFFF)) begin
            cnt_stalls <= cnt_stalls + 32'd1;
         end
         if (redirect && (cnt_flushes != 32'hFFFF_FFFF)) begin
            cnt_flushes <= cnt_flushes + 32'd1;
         end
      end
   end
`else
   assign cnt_cycles  = '0;
   assign cnt_stalls  = '0;
   assign cnt_flushes = '0;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: reference model feeds an expectation queue popped after each edge.
// A second instance with a high RESET_PC covers the jump-region case.
module tb_mips_fetch_stage;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] cycles;
      logic [31:0] stalls;
      logic [31:0] flushes;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        stall_if, branch_taken, jump;
   logic [15:0] branch_offset;
   logic [25:0] jump_index;
   logic [31:0] imem_rdata, imem_addr, pc, instr, ifid_instr, ifid_pc_plus4;
   logic        ifid_valid;
   logic [31:0] cnt_cycles, cnt_stalls, cnt_flushes;

   logic        hi_stall, hi_jump;
   logic [31:0] hi_rdata, hi_addr, hi_pc, hi_instr, hi_ifid_instr, hi_ifid_pc4;
   logic        hi_valid;
   logic [31:0] hi_cyc, hi_stl, hi_fls;

   exp_t sb[$];
   exp_t m;
   int   checks = 0;
   int   errors = 0;

   assign imem_rdata = imem_addr;
   assign hi_rdata   = hi_addr;

   mips_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clock(clock), .reset(reset), .stall_if(stall_if), .branch_taken(branch_taken),
      .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
      .imem_rdata(imem_rdata), .imem_addr(imem_addr), .pc(pc), .instr(instr),
      .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
      .cnt_cycles(cnt_cycles), .cnt_stalls(cnt_stalls), .cnt_flushes(cnt_flushes)
   );

   mips_fetch_stage #(.RESET_PC(32'hA000_000C)) dut_hi (
      .clock(clock), .reset(reset), .stall_if(hi_stall), .branch_taken(1'b0),
      .branch_offset(16'h0), .jump(hi_jump), .jump_index(26'h0),
      .imem_rdata(hi_rdata), .imem_addr(hi_addr), .pc(hi_pc), .instr(hi_instr),
      .ifid_instr(hi_ifid_instr), .ifid_pc_plus4(hi_ifid_pc4), .ifid_valid(hi_valid),
      .cnt_cycles(hi_cyc), .cnt_stalls(hi_stl), .cnt_flushes(hi_fls)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic model_reset();
      m = '{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, cycles: 32'h0, stalls: 32'h0, flushes: 32'h0};
   endtask

   // Drive one edge worth of ID-stage inputs, predict the result and queue it.
   task automatic cycle(input logic s, input logic b, input logic [15:0] off, input logic j, input logic [25:0] idx);
      exp_t e;
      logic [31:0] bt, jt;
      stall_if = s; branch_taken = b; branch_offset = off; jump = j; jump_index = idx;
      bt = m.pc4 + {{14{off[15]}}, off, 2'b00};
      jt = {m.pc4[31:28], idx, 2'b00};
      e = m;
      e.cycles = sat_inc(m.cycles);
      if (s) begin
         e.stalls = sat_inc(m.stalls);
      end else if (b || j) begin
         e.pc = b ? bt : jt;
         e.instr = 32'h0; e.pc4 = 32'h0; e.valid = 1'b0;
         e.flushes = sat_inc(m.flushes);
      end else begin
         e.pc = m.pc + 32'd4; e.instr = m.pc; e.pc4 = m.pc + 32'd4; e.valid = 1'b1;
      end
      sb.push_back(e);
      m = e;
      @(posedge clock);
      #1;
      stall_if = 1'b0; branch_taken = 1'b0; jump = 1'b0;
   endtask

   // Jump to addr then fetch once, leaving pc = addr+4 and ifid_pc_plus4 = addr+4.
   task automatic goto(input logic [31:0] addr);
      exp_t e;
      cycle(1'b0, 1'b0, 16'h0, 1'b1, addr[27:2]);
      e = sb.pop_front(); checks++;
      if (pc !== e.pc) begin errors++; $display("[TB] FAIL goto_jump_pc: got %h expected %h", pc, e.pc); end
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
      e = sb.pop_front(); checks++;
      if (pc !== e.pc) begin errors++; $display("[TB] FAIL goto_fetch_pc: got %h expected %h", pc, e.pc); end
   endtask

   task automatic test_reset();
      exp_t e;
      reset = 1'b0;
      model_reset();
      repeat (4) @(posedge clock);
      #1;
      checks++;
      if (pc !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc_plus4 !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_state: got pc=%h v=%b ii=%h p4=%h expected 0", pc, ifid_valid, ifid_instr, ifid_pc_plus4);
      end
      checks++;
      if (cnt_cycles !== 32'h0) begin errors++; $display("[TB] FAIL reset_cnt: got %h expected 0", cnt_cycles); end
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || imem_addr !== e.pc || instr !== e.pc) begin
            errors++; $display("[TB] FAIL seq_pc: got pc=%h addr=%h instr=%h expected %h", pc, imem_addr, instr, e.pc);
         end
         checks++;
         if (ifid_instr !== e.instr || ifid_pc_plus4 !== e.pc4 || ifid_valid !== e.valid) begin
            errors++; $display("[TB] FAIL seq_ifid: got %h/%h/%b expected %h/%h/%b", ifid_instr, ifid_pc_plus4, ifid_valid, e.instr, e.pc4, e.valid);
         end
      end
      checks++;
      if (pc !== 32'd12 || ifid_instr !== 32'd8) begin errors++; $display("[TB] FAIL seq_const: got pc=%h ii=%h expected 0000000c/00000008", pc, ifid_instr); end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (cnt_cycles !== e.cycles) begin errors++; $display("[TB] FAIL cnt_cycles: got %h expected %h", cnt_cycles, e.cycles); end
`endif
   endtask

   task automatic test_stall();
      exp_t e;
      goto(32'd40);
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || pc !== 32'd44) begin errors++; $display("[TB] FAIL stall_pc: got %h expected %h", pc, e.pc); end
      checks++;
      if (ifid_instr !== e.instr || ifid_pc_plus4 !== e.pc4 || ifid_valid !== e.valid) begin
         errors++; $display("[TB] FAIL stall_ifid: got %h/%h/%b expected %h/%h/%b", ifid_instr, ifid_pc_plus4, ifid_valid, e.instr, e.pc4, e.valid);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (cnt_stalls !== e.stalls) begin errors++; $display("[TB] FAIL cnt_stalls: got %h expected %h", cnt_stalls, e.stalls); end
`else
      checks++;
      if (cnt_stalls !== 32'h0) begin errors++; $display("[TB] FAIL cnt_stalls_off: got %h expected 0", cnt_stalls); end
`endif
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || pc !== 32'd48) begin errors++; $display("[TB] FAIL stall_release_pc: got %h expected %h", pc, e.pc); end
   endtask

   task automatic test_branch();
      exp_t e;
      goto(32'd52);
      cycle(1'b0, 1'b1, 16'd12, 1'b0, 26'h0);
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || pc !== 32'd104) begin errors++; $display("[TB] FAIL branch_fwd_pc: got %h expected %h", pc, e.pc); end
      checks++;
      if (ifid_instr !== 32'h0 || ifid_valid !== 1'b0 || ifid_pc_plus4 !== 32'h0) begin
         errors++; $display("[TB] FAIL branch_flush: got %h/%b/%h expected 0/0/0", ifid_instr, ifid_valid, ifid_pc_plus4);
      end
      goto(32'd52);
      cycle(1'b0, 1'b1, 16'hFFFF, 1'b0, 26'h0);
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || pc !== 32'd52) begin errors++; $display("[TB] FAIL branch_back_pc: got %h expected %h", pc, e.pc); end
   endtask

   task automatic test_jump();
      exp_t e;
      goto(32'd32);
      cycle(1'b0, 1'b0, 16'h0, 1'b1, 26'd10);
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || pc !== 32'd40 || ifid_instr !== 32'h0) begin
         errors++; $display("[TB] FAIL jump_pc: got pc=%h ii=%h expected %h/0", pc, ifid_instr, e.pc);
      end
      hi_stall = 1'b0;
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc) begin errors++; $display("[TB] FAIL jump_main_pc: got %h expected %h", pc, e.pc); end
      checks++;
      if (hi_ifid_pc4 !== 32'hA000_0010 || hi_ifid_instr !== 32'hA000_000C) begin
         errors++; $display("[TB] FAIL hi_fetch: got %h/%h expected a0000010/a000000c", hi_ifid_pc4, hi_ifid_instr);
      end
      hi_jump = 1'b1;
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
      e = sb.pop_front();
      hi_jump = 1'b0;
      hi_stall = 1'b1;
      checks++;
      if (pc !== e.pc) begin errors++; $display("[TB] FAIL jump_main_pc2: got %h expected %h", pc, e.pc); end
      checks++;
      if (hi_pc !== 32'hA000_0000 || hi_instr !== 32'hA000_0000 || hi_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL hi_jump: got pc=%h instr=%h v=%b expected a0000000/a0000000/0", hi_pc, hi_instr, hi_valid);
      end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      cycle(1'b1, 1'b1, 16'd5, 1'b0, 26'h0);
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || ifid_pc_plus4 !== e.pc4 || ifid_valid !== e.valid) begin
         errors++; $display("[TB] FAIL stall_over_branch: got %h/%h/%b expected %h/%h/%b", pc, ifid_pc_plus4, ifid_valid, e.pc, e.pc4, e.valid);
      end
      cycle(1'b0, 1'b1, 16'd1, 1'b1, 26'd3);
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || pc !== 32'd52) begin errors++; $display("[TB] FAIL branch_over_jump: got %h expected %h", pc, e.pc); end
      cycle(1'b0, 1'b1, 16'hFFFF, 1'b0, 26'h0);
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL branch_to_top: got %h expected %h", pc, e.pc); end
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
      e = sb.pop_front();
      checks++;
      if (pc !== 32'h0 || ifid_pc_plus4 !== 32'h0 || ifid_instr !== 32'hFFFF_FFFC || ifid_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL pc_wrap: got pc=%h p4=%h ii=%h v=%b expected %h/%h/%h/%b", pc, ifid_pc_plus4, ifid_instr, ifid_valid, e.pc, e.pc4, e.instr, e.valid);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (cnt_flushes !== e.flushes) begin errors++; $display("[TB] FAIL cnt_flushes: got %h expected %h", cnt_flushes, e.flushes); end
`else
      checks++;
      if (cnt_flushes !== 32'h0 || cnt_cycles !== 32'h0) begin errors++; $display("[TB] FAIL cnt_off: got %h/%h expected 0/0", cnt_flushes, cnt_cycles); end
`endif
   endtask

   task automatic test_async_reset();
      exp_t e;
      goto(32'd84);
      checks++;
      if (pc !== 32'd88) begin errors++; $display("[TB] FAIL pre_reset_pc: got %h expected 00000058", pc); end
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (pc !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
         errors++; $display("[TB] FAIL async_reset: got pc=%h v=%b ii=%h expected 0/0/0", pc, ifid_valid, ifid_instr);
      end
      checks++;
      if (cnt_cycles !== 32'h0 || cnt_stalls !== 32'h0 || cnt_flushes !== 32'h0) begin
         errors++; $display("[TB] FAIL async_reset_cnt: got %h/%h/%h expected 0", cnt_cycles, cnt_stalls, cnt_flushes);
      end
      checks++;
      if (hi_pc !== 32'hA000_000C || hi_cyc !== 32'h0 || hi_stl !== 32'h0 || hi_fls !== 32'h0) begin
         errors++; $display("[TB] FAIL hi_async_reset: got pc=%h cnt=%h/%h/%h expected a000000c/0", hi_pc, hi_cyc, hi_stl, hi_fls);
      end
      @(negedge clock);
      reset = 1'b1;
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || pc !== 32'd4) begin errors++; $display("[TB] FAIL post_reset_pc: got %h expected %h", pc, e.pc); end
   endtask

   initial begin
      reset = 1'b0;
      stall_if = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      branch_offset = 16'h0; jump_index = 26'h0;
      hi_stall = 1'b1; hi_jump = 1'b0;
      test_reset();
      test_stall();
      test_branch();
      test_jump();
      test_simultaneous();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_left: got %0d expected 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
IF stage of the 5-stage MIPS pipeline. Holds the PC and drives the instruction-memory address. Owns the IF/ID pipeline register. Applies load-use stalls and branch/jump redirects resolved in ID, flushing the wrong-path fetch to a NOP (32'h0). Feeds the ID stage and the pipeline display monitor (`instr`, `ifid_instr`).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).
PC_WIDTH, 32, width of PC, targets and pc+4 (fixed 32 for MIPS; kept for bench reuse).

Ports:
clock  input  1  pipeline clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; clears all state
stall_if  input  1  from hazard unit: hold PC and IF/ID this cycle (load-use bubble)
branch_taken  input  1  ID-stage beq/bne resolved taken (PCSrc)
branch_offset  input  16  ID-stage immediate, signed word offset
jump  input  1  ID-stage j instruction
jump_index  input  26  ID-stage instr[25:0]
imem_rdata  input  32  instruction word at imem_addr, combinational read
imem_addr  output  32  byte address to instruction memory, equals pc
pc  output  32  current fetch PC
instr  output  32  word currently fetched, equals imem_rdata
ifid_instr  output  32  IF/ID instruction register
ifid_pc_plus4  output  32  IF/ID pc+4 register
ifid_valid  output  1  IF/ID holds a real (non-flushed) instruction
cnt_cycles, cnt_stalls, cnt_flushes  output  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (reset==0, asynchronous): pc=RESET_PC, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0, counters=0. Takes effect immediately, mid-operation included. First fetch happens on the first rising edge after release.
- Combinational outputs: imem_addr=pc; instr=imem_rdata. IF/ID latency is 1 cycle.
- pc_plus4 = pc+4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000, no flag).
- branch_target = ifid_pc_plus4 + (sign_extend(branch_offset) << 2), modulo 2^32.
- jump_target = {ifid_pc_plus4[31:28], jump_index, 2'b00}.
- Priority per rising edge, highest first:
  1. stall_if=1: pc, ifid_instr, ifid_pc_plus4 and ifid_valid hold. branch_taken and jump are ignored, because the ID instruction repeats and reasserts them next cycle.
  2. branch_taken=1: pc<=branch_target; ifid_instr<=0; ifid_pc_plus4<=0; ifid_valid<=0 (flush).
  3. jump=1: pc<=jump_target; same flush as case 2.
  4. Otherwise: pc<=pc_plus4; ifid_instr<=imem_rdata; ifid_pc_plus4<=pc_plus4; ifid_valid<=1.
- branch_taken and jump both 1 (illegal from ID): branch wins, no error.
- Targets are used as computed. Low 2 bits are always 00 by construction for jumps. RESET_PC alignment is the integrator's responsibility.
- A flushed IF/ID slot decodes as sll $0,$0,0 and has no architectural effect downstream.
- Back-to-back stalls hold indefinitely. A redirect on the first non-stalled cycle after a stall is honoured normally.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: on each rising edge out of reset, cnt_cycles+1. cnt_stalls+1 when stall_if=1. cnt_flushes+1 when a redirect is taken (case 2 or 3 above). All counters saturate at 32'hFFFF_FFFF. Async-cleared by reset.
- Not defined: no counter flops are built; the three ports are tied to 32'h0.

Test Plan:
1. Reset held 4 cycles, then released with imem returning word=addr -> pc=0 during reset. Edges 1..3 give pc=4,8,12. ifid_instr=0,4,8; ifid_pc_plus4=4,8,12; ifid_valid=1.
2. At pc=44, assert stall_if for 1 cycle -> pc stays 44 and IF/ID unchanged for that edge. Next edge pc=48. With FETCH_PERF_CNT_EN, cnt_stalls=1.
3. ifid_pc_plus4=56, branch_taken=1, branch_offset=16'd12 -> pc=104, ifid_instr=0, ifid_valid=0. With offset 16'hFFFF from ifid_pc_plus4=56 -> pc=52.
4. ifid_pc_plus4=36, jump=1, jump_index=26'd10 -> pc=40, ifid_instr=0. With ifid_pc_plus4=32'hA000_0010, jump_index=0 -> pc=32'hA000_0000.
5. Simultaneous events: stall_if=1 with branch_taken=1 -> no change. branch_taken=1 with jump=1 -> branch target taken. Then pc=32'hFFFF_FFFC unstalled -> pc=0, ifid_pc_plus4=0.
6. Assert reset mid-run at pc=88 between edges -> pc=RESET_PC and ifid_valid=0 immediately without a clock edge. Counters=0 when FETCH_PERF_CNT_EN is defined.
